// File: rtl/std_lane_receiver_pkg.sv
// -----------------------------------------------------------------------------
// std_lane_receiver_pkg
//   Definitions shared by the lane receiver and its per-lane FIFO: the
//   manager/stack interface sizes, the message delineator encodings, the
//   arbiter state type and the lane-index width helper.
// -----------------------------------------------------------------------------
package std_lane_receiver_pkg;

    // Manager / stack-interface sizes
    localparam int MGR_NUM_OF_EXEC_LANES       = 2;
    localparam int STACK_DOWN_INTF_STRM_DATA_W = 64;
    localparam int COMMON_STD_INTF_CNTL_W      = 2;

    // Message delineator encodings
    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    // Stack-bus arbiter states
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a lane index; a single lane still needs a 1-bit field
    function automatic int lane_idx_w(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/std_lane_fifo.sv
// -----------------------------------------------------------------------------
// std_lane_fifo
//   Per-lane buffer of DEPTH entries with wrapping read/write pointers and an
//   occupancy count one bit wider than the pointers.
//
// Ports
//   clk            block clock
//   reset_poweron  asynchronous active-low reset (pointers and count only)
//   push           write push_data at the tail (ignored when full)
//   push_data      entry to store
//   pop            drop the head entry (ignored when empty)
//   head_data      current head entry
//   empty          count is zero
//   not_full       count is below DEPTH, from registered state only
// -----------------------------------------------------------------------------
module std_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             reset_poweron,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             not_full
);

    localparam int             PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Guarding push/pop here keeps the count consistent even if a caller
    // requests an impossible operation; DEPTH is a power of two so the
    // pointers wrap by plain overflow.
    always_comb begin
        do_push  = push && (count_q != FULL_COUNT);
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once the count covers it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign not_full  = (count_q != FULL_COUNT);

endmodule

// File: rtl/std_lane_receiver.sv
// -----------------------------------------------------------------------------
// std_lane_receiver
//   Buffers delineated words from NUM_LANES memory-read-controller lanes and
//   forwards them onto a single stack bus, one whole message at a time, with
//   round-robin selection between messages and sticky per-lane protocol-error
//   flags.
//
// Ports
//   clk                   block clock
//   reset_poweron         asynchronous active-low reset
//   mrc__std__lane_valid  per-lane word valid
//   mrc__std__lane_cntl   per-lane delineator, lane i at [i*CNTL_W +: CNTL_W]
//   mrc__std__lane_data   per-lane data, lane i at [i*DATA_W +: DATA_W]
//   std__mrc__lane_ready  per-lane ready (lane buffer has room)
//   std__stk__valid       stack-bus word valid
//   std__stk__cntl        stack-bus delineator (0 when not valid)
//   std__stk__data        stack-bus data (0 when not valid)
//   std__stk__lane        source lane of the stack word (0 when not valid)
//   stk__std__ready       stack bus accepts the word
//   std__sys__lane_err    sticky per-lane protocol-error flags
// -----------------------------------------------------------------------------
module std_lane_receiver
    import std_lane_receiver_pkg::*;
#(
    parameter int NUM_LANES  = MGR_NUM_OF_EXEC_LANES,
    parameter int DATA_W     = STACK_DOWN_INTF_STRM_DATA_W,
    parameter int CNTL_W     = COMMON_STD_INTF_CNTL_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset_poweron,
    input  logic [NUM_LANES-1:0]                mrc__std__lane_valid,
    input  logic [NUM_LANES*CNTL_W-1:0]         mrc__std__lane_cntl,
    input  logic [NUM_LANES*DATA_W-1:0]         mrc__std__lane_data,
    output logic [NUM_LANES-1:0]                std__mrc__lane_ready,
    output logic                                std__stk__valid,
    output logic [CNTL_W-1:0]                   std__stk__cntl,
    output logic [DATA_W-1:0]                   std__stk__data,
    output logic [lane_idx_w(NUM_LANES)-1:0]    std__stk__lane,
    input  logic                                stk__std__ready,
    output logic [NUM_LANES-1:0]                std__sys__lane_err
);

    localparam int                LANE_W    = lane_idx_w(NUM_LANES);
    localparam int                ENTRY_W   = CNTL_W + DATA_W;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    arb_state_e          state_q, state_d;
    logic [LANE_W-1:0]   grant_q, grant_d;
    logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_LANES-1:0] in_msg_q, in_msg_d;
    logic [NUM_LANES-1:0] lane_err_q, lane_err_d;
    logic                ready_en_q, ready_en_d;

    logic [NUM_LANES-1:0] lane_push;
    logic [NUM_LANES-1:0] lane_pop;
    logic [NUM_LANES-1:0] lane_empty;
    logic [NUM_LANES-1:0] lane_not_full;
    logic [ENTRY_W-1:0]   head_entry [NUM_LANES];

    logic [LANE_W-1:0]   sel_lane;
    logic [LANE_W-1:0]   cand_lane;
    int                  cand_idx;
    logic                stk_valid;
    logic                stk_xfer;
    logic [ENTRY_W-1:0]  head_sel;
    logic [1:0]          head_cntl;
    logic [1:0]          in_cntl;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        std_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk           (clk),
            .reset_poweron (reset_poweron),
            .push          (lane_push[i]),
            .push_data     ({mrc__std__lane_cntl[i*CNTL_W +: CNTL_W],
                             mrc__std__lane_data[i*DATA_W +: DATA_W]}),
            .pop           (lane_pop[i]),
            .head_data     (head_entry[i]),
            .empty         (lane_empty[i]),
            .not_full      (lane_not_full[i])
        );
    end

    // Lane side: ready is held low until the first edge after reset, then
    // follows registered buffer room. Each accepted word updates the lane's
    // in-message tracking; a delineator that does not fit the current state
    // raises the sticky error but the word is still stored.
    always_comb begin
        ready_en_d           = 1'b1;
        std__mrc__lane_ready = lane_not_full & {NUM_LANES{ready_en_q}};
        lane_push            = mrc__std__lane_valid & std__mrc__lane_ready;
        in_msg_d             = in_msg_q;
        lane_err_d           = lane_err_q;
        in_cntl              = '0;

        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_push[i]) begin
                in_cntl = mrc__std__lane_cntl[i*CNTL_W +: 2];
                case (in_cntl)
                    CNTL_SOM: begin
                        if (in_msg_q[i]) lane_err_d[i] = 1'b1;
                        in_msg_d[i] = 1'b1;
                    end
                    CNTL_SOM_EOM: begin
                        if (in_msg_q[i]) lane_err_d[i] = 1'b1;
                        in_msg_d[i] = 1'b0;
                    end
                    CNTL_EOM: begin
                        if (!in_msg_q[i]) lane_err_d[i] = 1'b1;
                        in_msg_d[i] = 1'b0;
                    end
                    default: begin
                        if (!in_msg_q[i]) lane_err_d[i] = 1'b1;
                    end
                endcase
            end
        end
    end

    // Stack side: when idle the first non-empty lane at or after rr_ptr is
    // chosen combinationally so a freshly buffered head goes out the next
    // cycle. Scanning from the farthest offset down lets the nearest lane
    // win. A SOM locks the grant so no other lane interleaves; EOM/SOM_EOM
    // releases it and moves rr_ptr past the lane. A stray MOM/EOM head in
    // idle is sent as a one-word grant so a broken lane cannot stall the bus.
    always_comb begin
        sel_lane  = rr_ptr_q;
        stk_valid = 1'b0;
        cand_idx  = 0;
        cand_lane = '0;

        if (state_q == ARB_LOCKED) begin
            sel_lane  = grant_q;
            stk_valid = !lane_empty[grant_q];
        end else begin
            for (int k = NUM_LANES - 1; k >= 0; k--) begin
                cand_idx = int'(rr_ptr_q) + k;
                if (cand_idx >= NUM_LANES) cand_idx = cand_idx - NUM_LANES;
                cand_lane = LANE_W'(cand_idx);
                if (!lane_empty[cand_lane]) begin
                    sel_lane  = cand_lane;
                    stk_valid = 1'b1;
                end
            end
        end

        head_sel        = head_entry[sel_lane];
        head_cntl       = head_sel[DATA_W +: 2];
        std__stk__valid = stk_valid;
        std__stk__cntl  = stk_valid ? head_sel[DATA_W +: CNTL_W] : '0;
        std__stk__data  = stk_valid ? head_sel[DATA_W-1:0] : '0;
        std__stk__lane  = stk_valid ? sel_lane : '0;

        stk_xfer = stk_valid && stk__std__ready;
        lane_pop = '0;
        if (stk_xfer) lane_pop[sel_lane] = 1'b1;

        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (stk_xfer) begin
            case (head_cntl)
                CNTL_SOM: begin
                    state_d = ARB_LOCKED;
                    grant_d = sel_lane;
                end
                CNTL_EOM, CNTL_SOM_EOM: begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (sel_lane == LAST_LANE) ? '0 : sel_lane + 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            in_msg_q   <= '0;
            lane_err_q <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            in_msg_q   <= in_msg_d;
            lane_err_q <= lane_err_d;
            ready_en_q <= ready_en_d;
        end
    end

    assign std__sys__lane_err = lane_err_q;

endmodule
